// File: rtl/prob_pulse_pkg.sv
// Shared types and helpers for the probability-to-pulse-train generator.
package prob_pulse_pkg;

    localparam int unsigned LFSR_W = 7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // x^7 + x^6 + 1, Fibonacci form, shifting left.
    function automatic logic [LFSR_W-1:0] lfsr7_next(input logic [LFSR_W-1:0] q);
        return {q[5:0], q[6] ^ q[5]};
    endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit maximal LFSR with a load port that refuses the all-zero lockup state.
module lfsr7
    import prob_pulse_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 7'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (load) begin
            q <= (load_val == '0) ? SEED : load_val;
        end else if (en) begin
            q <= lfsr7_next(q);
        end
    end

endmodule

// File: rtl/prob_pulse_gen.sv
// Bernoulli pulse-train generator: LFSR <= latched probability over a fixed slot window.
module prob_pulse_gen
    import prob_pulse_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED   = 7'h01,
    parameter int unsigned       WINDOW = 127
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LFSR_W-1:0] prob,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic              x_pulse,
    output logic              busy,
    output logic              done,
    output logic [LFSR_W-1:0] pulse_cnt
);

    localparam logic [LFSR_W-1:0] LAST_SLOT = LFSR_W'(WINDOW - 1);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] prob_q, prob_d;
    logic [LFSR_W-1:0] slot_q, slot_d;
    logic [LFSR_W-1:0] cnt_q, cnt_d;
    logic [LFSR_W-1:0] lfsr;

    lfsr7 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == RUN),
        .load     ((state_q == IDLE) && seed_load),
        .load_val (seed),
        .q        (lfsr)
    );

    // Outputs come from registers only, so async reset clears them immediately.
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign x_pulse   = busy && (lfsr <= prob_q);
    assign pulse_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        prob_d  = prob_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    prob_d  = prob;
                    slot_d  = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + {{(LFSR_W-1){1'b0}}, x_pulse};
                if (slot_q == LAST_SLOT) begin
                    state_d = DONE;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prob_q  <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prob_q  <= prob_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prob_pulse_gen.sv
// Scoreboard bench for prob_pulse_gen over four window sizes (8, 127, 1, 2).
module tb_prob_pulse_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       seed_load;
    logic [6:0] prob;
    logic [6:0] seed;

    logic [3:0] x_v, busy_v, done_v;
    logic [6:0] cnt_v  [4];
    logic [6:0] lfsr_v [4];

    int checks   = 0;
    int failures = 0;
    int sel      = 0;
    int busy_cycles = 0;
    int done_seen   = 0;

    logic       exp_x_q [$];
    logic [6:0] exp_l_q [$];
    logic [6:0] exp_c_q [$];
    logic [6:0] m_lfsr;

    logic       ex;
    logic [6:0] el, ec;

    always #5 clk = ~clk;

    prob_pulse_gen #(.SEED(7'h01), .WINDOW(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start), .prob(prob), .seed_load(seed_load), .seed(seed),
        .x_pulse(x_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pulse_cnt(cnt_v[0])
    );
    prob_pulse_gen #(.SEED(7'h01), .WINDOW(127)) u_d127 (
        .clk(clk), .rst(rst), .start(start), .prob(prob), .seed_load(seed_load), .seed(seed),
        .x_pulse(x_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pulse_cnt(cnt_v[1])
    );
    prob_pulse_gen #(.SEED(7'h01), .WINDOW(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .prob(prob), .seed_load(seed_load), .seed(seed),
        .x_pulse(x_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pulse_cnt(cnt_v[2])
    );
    prob_pulse_gen #(.SEED(7'h01), .WINDOW(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start), .prob(prob), .seed_load(seed_load), .seed(seed),
        .x_pulse(x_v[3]), .busy(busy_v[3]), .done(done_v[3]), .pulse_cnt(cnt_v[3])
    );

    assign lfsr_v[0] = u_d8.lfsr;
    assign lfsr_v[1] = u_d127.lfsr;
    assign lfsr_v[2] = u_d1.lfsr;
    assign lfsr_v[3] = u_d2.lfsr;

    function automatic logic [6:0] step(input logic [6:0] q);
        return {q[5:0], q[6] ^ q[5]};
    endfunction

    // Scoreboard consumer: one entry per busy slot, one count per done strobe.
    always @(negedge clk) begin
        if (!rst && busy_v[sel]) begin
            busy_cycles++;
            checks++;
            if (exp_x_q.size() == 0) begin
                failures++;
                $display("FAIL slot_unexpected inst=%0d got busy=1 want no slot", sel);
            end else begin
                ex = exp_x_q.pop_front();
                el = exp_l_q.pop_front();
                if (x_v[sel] !== ex) begin
                    failures++;
                    $display("FAIL x_pulse inst=%0d lfsr=%h got=%b want=%b", sel, lfsr_v[sel],
                             x_v[sel], ex);
                end
                checks++;
                if (lfsr_v[sel] !== el) begin
                    failures++;
                    $display("FAIL lfsr_seq inst=%0d got=%h want=%h", sel, lfsr_v[sel], el);
                end
            end
        end
        if (!rst && done_v[sel]) begin
            done_seen++;
            checks++;
            if (exp_c_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected inst=%0d got done=1 want 0", sel);
            end else begin
                ec = exp_c_q.pop_front();
                if (cnt_v[sel] !== ec) begin
                    failures++;
                    $display("FAIL pulse_cnt inst=%0d got=%0d want=%0d", sel, cnt_v[sel], ec);
                end
            end
        end
    end

    task automatic push_run(input logic [6:0] p, input int win, output logic [6:0] c);
        c = '0;
        for (int i = 0; i < win; i++) begin
            exp_l_q.push_back(m_lfsr);
            exp_x_q.push_back(m_lfsr <= p);
            if (m_lfsr <= p) c = c + 7'd1;
            m_lfsr = step(m_lfsr);
        end
        exp_c_q.push_back(c);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; prob = '0; seed = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_lfsr = 7'h01;
        exp_x_q.delete(); exp_l_q.delete(); exp_c_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic seed_load_only(input logic [6:0] v);
        seed_load = 1'b1; seed = v;
        @(posedge clk); #1;
        seed_load = 1'b0; seed = 7'h7f;
        m_lfsr = (v == 7'h00) ? 7'h01 : v;
    endtask

    task automatic run(input int s, input logic [6:0] p, input int win, input logic ld,
                       input logic [6:0] sv, input logic poke, input string tag);
        int cyc, b0, d0;
        logic [6:0] c;
        sel = s;
        if (ld) m_lfsr = (sv == 7'h00) ? 7'h01 : sv;
        push_run(p, win, c);
        b0 = busy_cycles; d0 = done_seen;
        start = 1'b1; prob = p; seed_load = ld; seed = sv;
        @(posedge clk); #1;
        start = 1'b0; seed_load = 1'b0; prob = ~p; seed = 7'h55;
        cyc = 0;
        while (!done_v[s] && cyc < win + 10) begin
            start = poke && (cyc == 3);
            seed_load = poke && (cyc == 3);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; seed_load = 1'b0;
        checks++;
        if (cyc != win) begin
            failures++;
            $display("FAIL %s done_latency got=%0d want=%0d", tag, cyc + 1, win + 1);
        end
        @(negedge clk); #1;
        checks++;
        if (done_seen - d0 != 1) begin
            failures++;
            $display("FAIL %s done_count got=%0d want=1", tag, done_seen - d0);
        end
        checks++;
        if (busy_cycles - b0 != win) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", tag, busy_cycles - b0, win);
        end
        checks++;
        if (exp_x_q.size() != 0 || exp_c_q.size() != 0) begin
            failures++;
            $display("FAIL %s sb_leftover got=%0d/%0d want=0/0", tag, exp_x_q.size(),
                     exp_c_q.size());
            exp_x_q.delete(); exp_l_q.delete(); exp_c_q.delete();
        end
        @(posedge clk); #1;
        checks++;
        if (cnt_v[s] !== c || busy_v[s] !== 1'b0) begin
            failures++;
            $display("FAIL %s cnt_hold got=%0d busy=%b want=%0d busy=0", tag, cnt_v[s],
                     busy_v[s], c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; prob = '0; seed = '0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (x_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 ||
                cnt_v[i] !== 7'd0 || lfsr_v[i] !== 7'h01) begin
                failures++;
                $display("FAIL reset_state inst=%0d got x=%b b=%b d=%b c=%0d l=%h want 0 0 0 0 01",
                         i, x_v[i], busy_v[i], done_v[i], cnt_v[i], lfsr_v[i]);
            end
        end
        do_reset();
    endtask

    task automatic test_sequence();
        do_reset();
        run(0, 7'd127, 8, 1'b1, 7'h01, 1'b0, "sequence");
        checks++;
        if (cnt_v[0] !== 7'd8) begin
            failures++;
            $display("FAIL sequence_total got=%0d want=8", cnt_v[0]);
        end
    endtask

    task automatic test_density();
        logic [6:0] probs [3];
        probs[0] = 7'd0; probs[1] = 7'd64; probs[2] = 7'd127;
        do_reset();
        seed_load_only(7'h5a);
        for (int i = 0; i < 3; i++) begin
            run(1, probs[i], 127, 1'b0, 7'h00, 1'b0, "density");
            checks++;
            if (cnt_v[1] !== probs[i]) begin
                failures++;
                $display("FAIL density_total got=%0d want=%0d", cnt_v[1], probs[i]);
            end
        end
    endtask

    task automatic test_zero_seed();
        do_reset();
        seed_load_only(7'h33);
        seed_load_only(7'h00);
        run(2, 7'd127, 1, 1'b0, 7'h00, 1'b0, "zero_seed");
        checks++;
        if (cnt_v[2] !== 7'd1) begin
            failures++;
            $display("FAIL zero_seed_total got=%0d want=1", cnt_v[2]);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        run(0, 7'h40, 8, 1'b0, 7'h00, 1'b1, "ignored");
    endtask

    task automatic test_simultaneous();
        do_reset();
        run(3, 7'h30, 2, 1'b1, 7'h20, 1'b0, "simultaneous");
        checks++;
        if (cnt_v[3] !== 7'd1) begin
            failures++;
            $display("FAIL simultaneous_total got=%0d want=1", cnt_v[3]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] c;
        int d0;
        do_reset();
        sel = 0;
        push_run(7'd127, 8, c);
        start = 1'b1; prob = 7'd127;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (cnt_v[0] !== 7'd5 || busy_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre got cnt=%0d busy=%b want 5 1", cnt_v[0], busy_v[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || x_v[0] !== 1'b0 || cnt_v[0] !== 7'd0 || done_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrun_async got b=%b x=%b c=%0d d=%b want 0 0 0 0",
                     busy_v[0], x_v[0], cnt_v[0], done_v[0]);
        end
        exp_x_q.delete(); exp_l_q.delete(); exp_c_q.delete();
        d0 = done_seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_lfsr = 7'h01;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done_seen != d0 || done_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done got=%0d want=0", done_seen - d0);
        end
        run(0, 7'd127, 8, 1'b0, 7'h00, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_density();
        test_zero_seed();
        test_ignored();
        test_simultaneous();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
